// File: rtl/vga_pkg.sv
// Shared RGB332 layout, default 640x480@60 timing constants and counter widths
// for the VGA layer compositor.
package vga_pkg;

    localparam int RED_W   = 3;
    localparam int GREEN_W = 3;
    localparam int BLUE_W  = 2;
    localparam int RGB_W   = RED_W + GREEN_W + BLUE_W;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Raster counters and sprite hit arithmetic share one 11-bit width so that
    // sprite_x + SPRITE_W - 1 never wraps for 10-bit positions.
    localparam int CNT_W = 11;
    localparam int POS_W = 10;

    typedef struct packed {
        logic [RED_W-1:0]   r;
        logic [GREEN_W-1:0] g;
        logic [BLUE_W-1:0]  b;
    } rgb332_t;

endpackage

// File: rtl/vga_timing.sv
// Raster generator: half-rate pixel enable, h/v counters, raw active-low syncs,
// active-region flag, screen coordinates and the end-of-frame tick.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             pix_en_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             hs_raw_o,
    output logic             vs_raw_o,
    output logic             active_o,
    output logic             eof_o
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_START  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_START  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] H_END    = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_END    = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    logic             pix_en_q;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_en_q <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            pix_en_q <= ~pix_en_q;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign pix_en_o = pix_en_q;
    assign x_o      = hcount_q - H_START;
    assign y_o      = vcount_q - V_START;
    assign hs_raw_o = (hcount_q >= H_SYNC_E);
    assign vs_raw_o = (vcount_q >= V_SYNC_E);
    assign active_o = (hcount_q >= H_START) && (hcount_q < H_END) &&
                      (vcount_q >= V_START) && (vcount_q < V_END);
    // First line after the visible area; a fresh start from reset never lands here.
    assign eof_o    = pix_en_q && (hcount_q == '0) && (vcount_q == V_END);

endmodule

// File: rtl/vga_layer_compositor.sv
// Sprite layer compositor over a VGA raster: frame-shadowed sprite registers, priority
// hit test and a two-tick colour pipeline. Define VGA_COLLISION_EN for the collision port.
module vga_layer_compositor
    import vga_pkg::*;
#(
    parameter int               H_ACTIVE    = H_ACTIVE_DEF,
    parameter int               H_FP        = H_FP_DEF,
    parameter int               H_SYNC      = H_SYNC_DEF,
    parameter int               H_BP        = H_BP_DEF,
    parameter int               V_ACTIVE    = V_ACTIVE_DEF,
    parameter int               V_FP        = V_FP_DEF,
    parameter int               V_SYNC      = V_SYNC_DEF,
    parameter int               V_BP        = V_BP_DEF,
    parameter int               NUM_SPRITES = 3,
    parameter int               SPRITE_W    = 8,
    parameter int               SPRITE_H    = 8,
    parameter logic [RGB_W-1:0] BG_COLOR    = 8'b001_000_01
) (
    input  logic                           clk50M,
    input  logic                           reset,
    input  logic [POS_W*NUM_SPRITES-1:0]   sprite_x,
    input  logic [POS_W*NUM_SPRITES-1:0]   sprite_y,
    input  logic [RGB_W*NUM_SPRITES-1:0]   sprite_color,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    output logic [RED_W-1:0]               red,
    output logic [GREEN_W-1:0]             green,
    output logic [BLUE_W-1:0]              blue,
    output logic                           HS,
    output logic                           VS,
    output logic                           endofframe,
    output logic [15:0]                    frame_count
`ifdef VGA_COLLISION_EN
    ,
    output logic [NUM_SPRITES-1:0]         collision
`endif
);
    localparam logic [CNT_W-1:0] SPR_W_M1 = CNT_W'(SPRITE_W - 1);
    localparam logic [CNT_W-1:0] SPR_H_M1 = CNT_W'(SPRITE_H - 1);

    logic             pix_en, active, hs_raw, vs_raw, eof;
    logic [CNT_W-1:0] x, y;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk_i    (clk50M),
        .rst_i    (reset),
        .pix_en_o (pix_en),
        .x_o      (x),
        .y_o      (y),
        .hs_raw_o (hs_raw),
        .vs_raw_o (vs_raw),
        .active_o (active),
        .eof_o    (eof)
    );

    logic [POS_W*NUM_SPRITES-1:0] shx_q, shy_q;
    logic [RGB_W*NUM_SPRITES-1:0] shc_q;
    logic [NUM_SPRITES-1:0]       she_q;

    // Sprite state only changes between frames so a frame is never torn.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            shx_q <= '0;
            shy_q <= '0;
            shc_q <= '0;
            she_q <= '0;
        end else if (eof) begin
            shx_q <= sprite_x;
            shy_q <= sprite_y;
            shc_q <= sprite_color;
            she_q <= sprite_en;
        end
    end

    logic [NUM_SPRITES-1:0] hit;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
        logic [CNT_W-1:0] sx, sy;
        assign sx     = CNT_W'(shx_q[i*POS_W +: POS_W]);
        assign sy     = CNT_W'(shy_q[i*POS_W +: POS_W]);
        assign hit[i] = she_q[i] && (x >= sx) && (x <= sx + SPR_W_M1) &&
                        (y >= sy) && (y <= sy + SPR_H_M1);
    end

    logic [RGB_W-1:0] pix_d;

    // Walk from the highest index down so the lowest-index hit is applied last.
    always_comb begin
        pix_d = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) pix_d = shc_q[i*RGB_W +: RGB_W];
        end
        if (!active) pix_d = '0;
    end

    rgb332_t pix1_q, pix_q;
    logic    hs1_q, vs1_q, hs_q, vs_q;

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            pix1_q <= '0;
            pix_q  <= '0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
        end else if (pix_en) begin
            pix1_q <= rgb332_t'(pix_d);
            pix_q  <= pix1_q;
            hs1_q  <= hs_raw;
            vs1_q  <= vs_raw;
            hs_q   <= hs1_q;
            vs_q   <= vs1_q;
        end
    end

    logic [15:0] frame_count_q;

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) frame_count_q <= '0;
        else if (eof) frame_count_q <= frame_count_q + 16'd1;
    end

    assign red         = pix_q.r;
    assign green       = pix_q.g;
    assign blue        = pix_q.b;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign endofframe  = eof;
    assign frame_count = frame_count_q;

`ifdef VGA_COLLISION_EN
    logic [NUM_SPRITES-1:0] acc_q, acc_d, collision_q;

    // On the frame tick the accumulator restarts; that tick's own hits belong to the new frame.
    always_comb begin
        acc_d = eof ? '0 : acc_q;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (active && hit[i] && ((hit & ~(NUM_SPRITES'(1) << i)) != '0)) acc_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            collision_q <= '0;
        end else if (pix_en) begin
            acc_q <= acc_d;
            if (eof) collision_q <= acc_q;
        end
    end

    assign collision = collision_q;
`endif

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Scoreboard bench for vga_layer_compositor on a reduced raster; the reference model
// derives every pixel from its linear position since reset and the sprite rules.
module tb_vga_layer_compositor;

    localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 4;
    localparam int V_ACTIVE = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int NS = 3, SW = 4, SH = 3;
    localparam logic [7:0] BG = 8'b001_000_01;

    localparam int H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int FRAME_CLK = 2 * H_TOTAL * V_TOTAL;
    localparam int H_OFF     = H_SYNC + H_BP;
    localparam int V_OFF     = V_SYNC + V_BP;
    localparam int V_EOF     = V_OFF + V_ACTIVE;

    logic              clk50M = 1'b0;
    logic              reset  = 1'b1;
    logic [10*NS-1:0]  sprite_x, sprite_y;
    logic [8*NS-1:0]   sprite_color;
    logic [NS-1:0]     sprite_en;
    logic [2:0]        red, green;
    logic [1:0]        blue;
    logic              HS, VS, endofframe;
    logic [15:0]       frame_count;
`ifdef VGA_COLLISION_EN
    logic [NS-1:0]     collision;
`endif

    vga_layer_compositor #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .NUM_SPRITES (NS), .SPRITE_W (SW), .SPRITE_H (SH), .BG_COLOR (BG)
    ) dut (
        .clk50M       (clk50M),
        .reset        (reset),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_color (sprite_color),
        .sprite_en    (sprite_en),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .HS           (HS),
        .VS           (VS),
        .endofframe   (endofframe),
        .frame_count  (frame_count)
`ifdef VGA_COLLISION_EN
        ,
        .collision    (collision)
`endif
    );

    always #5 clk50M = ~clk50M;

    typedef struct {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          n     = -1;
    bit          run   = 1'b0;
    int          m_x[NS];
    int          m_y[NS];
    logic [7:0]  m_c[NS];
    bit          m_en[NS];
    logic [15:0] m_fc;
    logic [NS-1:0] m_acc, m_coll;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic bit is_eof(input int k);
        return (k % H_TOTAL == 0) && ((k / H_TOTAL) % V_TOTAL == V_EOF);
    endfunction

    function automatic logic [NS-1:0] hits_at(input int x, input int y);
        logic [NS-1:0] m;
        m = '0;
        for (int i = 0; i < NS; i++)
            m[i] = m_en[i] && (x >= m_x[i]) && (x < m_x[i] + SW) && (y >= m_y[i]) && (y < m_y[i] + SH);
        return m;
    endfunction

    task automatic model_clear();
        sb.delete();
        m_fc   = '0;
        m_acc  = '0;
        m_coll = '0;
        for (int i = 0; i < NS; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_c[i] = 8'h00; m_en[i] = 1'b0;
        end
    endtask

    // Pixel k of the raster since reset is processed on the k-th pixel tick.
    task automatic model_tick(input int k);
        int h, v;
        bit act;
        logic [NS-1:0] m;
        exp_t e;
        h   = k % H_TOTAL;
        v   = (k / H_TOTAL) % V_TOTAL;
        act = (h >= H_OFF) && (h < H_OFF + H_ACTIVE) && (v >= V_OFF) && (v < V_OFF + V_ACTIVE);
        m   = act ? hits_at(h - H_OFF, v - V_OFF) : '0;
        e.rgb = 8'h00;
        if (act) begin
            e.rgb = BG;
            for (int i = 0; i < NS; i++) begin
                if (m[i]) begin
                    e.rgb = m_c[i];
                    break;
                end
            end
        end
        e.hs = (h >= H_SYNC);
        e.vs = (v >= V_SYNC);
        sb.push_back(e);
        if (is_eof(k)) begin
            m_coll = m_acc;
            m_acc  = '0;
            m_fc   = m_fc + 16'd1;
            for (int i = 0; i < NS; i++) begin
                m_x[i]  = int'(sprite_x[i*10 +: 10]);
                m_y[i]  = int'(sprite_y[i*10 +: 10]);
                m_c[i]  = sprite_color[i*8 +: 8];
                m_en[i] = sprite_en[i];
            end
        end
        if ($countones(m) >= 2) m_acc = m_acc | m;
    endtask

    initial begin
        forever begin
            @(posedge clk50M);
            if (run) begin
                n = n + 1;
                if (n % 2 == 1) model_tick((n - 1) / 2);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk50M);
            #1;
            if (run) begin
                if (n % 2 == 1) begin
                    if (sb.size() >= 2) begin
                        e = sb.pop_front();
                        check("pixel_rgb", {24'd0, red, green, blue}, {24'd0, e.rgb});
                        check("HS", {31'd0, HS}, {31'd0, e.hs});
                        check("VS", {31'd0, VS}, {31'd0, e.vs});
                    end
                    check("frame_count", {16'd0, frame_count}, {16'd0, m_fc});
`ifdef VGA_COLLISION_EN
                    check("collision", 32'(collision), 32'(m_coll));
`endif
                end
                check("endofframe", {31'd0, endofframe},
                      {31'd0, (n % 2 == 0) && is_eof(n / 2)});
            end
        end
    end

    task automatic set_sprite(input int i, input int x, input int y, input logic [7:0] c, input bit en);
        sprite_x[i*10 +: 10]    = 10'(x);
        sprite_y[i*10 +: 10]    = 10'(y);
        sprite_color[i*8 +: 8]  = c;
        sprite_en[i]            = en;
    endtask

    task automatic run_cycles(input int cnt);
        repeat (cnt) @(negedge clk50M);
    endtask

    task automatic release_reset();
        @(negedge clk50M);
        reset = 1'b0;
        model_clear();
        n   = -1;
        run = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rgb"}, {24'd0, red, green, blue}, 32'd0);
        check({tag, "_HS"}, {31'd0, HS}, 32'd1);
        check({tag, "_VS"}, {31'd0, VS}, 32'd1);
        check({tag, "_frame_count"}, {16'd0, frame_count}, 32'd0);
        check({tag, "_endofframe"}, {31'd0, endofframe}, 32'd0);
`ifdef VGA_COLLISION_EN
        check({tag, "_collision"}, 32'(collision), 32'd0);
`endif
    endtask

    initial begin
        sprite_x     = '0;
        sprite_y     = '0;
        sprite_color = '0;
        sprite_en    = '0;
        model_clear();
        reset = 1'b1;
        run_cycles(3);
        check_reset_state("reset");

        // Background-only frames: sync timing, frame ticks and the frame counter.
        release_reset();
        run_cycles(2 * FRAME_CLK);
        check("frame_count_two_frames", {16'd0, frame_count}, 32'd2);

        // Single sprite in the top-left corner.
        set_sprite(0, 0, 0, 8'hE0, 1'b1);
        run_cycles(2 * FRAME_CLK);

        // Overlapping sprites: priority and collision reporting.
        set_sprite(0, 5, 5, 8'hFF, 1'b1);
        set_sprite(1, 7, 6, 8'h03, 1'b1);
        run_cycles(2 * FRAME_CLK);
`ifdef VGA_COLLISION_EN
        check("collision_overlap", 32'(collision), 32'b011);
`endif
        set_sprite(1, 7, 6, 8'h03, 1'b0);
        run_cycles(2 * FRAME_CLK);
`ifdef VGA_COLLISION_EN
        check("collision_cleared", 32'(collision), 32'b000);
`endif

        // Clipping at the right/bottom edges and positions far off-screen.
        set_sprite(0, H_ACTIVE - 2, V_ACTIVE - 1, 8'h1C, 1'b1);
        set_sprite(1, 1021, 1022, 8'h55, 1'b1);
        set_sprite(2, H_ACTIVE - 1, 0, 8'hAA, 1'b1);
        run_cycles(2 * FRAME_CLK);

        // Mid-frame input change must wait for the next frame boundary.
        run_cycles(FRAME_CLK / 2);
        set_sprite(0, 3, 4, 8'h92, 1'b1);
        run_cycles(2 * FRAME_CLK);

        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < NS; i++) begin
                int rx, ry;
                rx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1023))
                                                 : int'($urandom_range(0, H_ACTIVE + 2));
                ry = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1023))
                                                 : int'($urandom_range(0, V_ACTIVE + 2));
                set_sprite(i, rx, ry, 8'($urandom), 1'($urandom_range(0, 3) != 0));
            end
            run_cycles(int'($urandom_range(100, 2 * FRAME_CLK)));
        end

        // Asynchronous reset in the middle of a frame, then a clean restart.
        run_cycles(FRAME_CLK / 2 + 37);
        @(negedge clk50M);
        run   = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_state("midframe_reset");
        run_cycles(2);
        release_reset();
        run_cycles(2 * FRAME_CLK);
        check("frame_count_after_restart", {16'd0, frame_count}, 32'd2);

        run = 1'b0;
        @(negedge clk50M);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_layer_compositor.md
VGA_LAYER_COMPOSITOR -- requirements
Module: vga_layer_compositor

Interface
REQ-001 Parameter: H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter: H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter: V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter: V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch, sync and back porch in lines.
REQ-005 Parameter: NUM_SPRITES, default 3 (range 1..8), sprite layer count.
REQ-006 Parameter: SPRITE_W/SPRITE_H, default 8/8, sprite size in pixels.
REQ-007 Parameter: BG_COLOR, default 8'b001_000_01, RGB332 background.
REQ-008 Ports: clk50M in 1, the only clock; reset in 1, asynchronous, active-high.
REQ-009 Ports: sprite_x, sprite_y in 10*NUM_SPRITES each, packed top-left positions in screen pixels; sprite_color in 8*NUM_SPRITES, packed RGB332; sprite_en in NUM_SPRITES, per-sprite visibility.
REQ-010 Ports: red out 3, green out 3, blue out 2, registered colour outputs.
REQ-011 Ports: HS, VS out 1 each, active-low syncs; endofframe out 1, frame-boundary pulse; frame_count out 16, completed-frame count.
REQ-012 Ports: collision out NUM_SPRITES, per-sprite collision mask, present only with VGA_COLLISION_EN.

Function
REQ-013 pix_en shall toggle on every clk50M edge, starting at 0 after reset; all pixel-rate state shall advance only on cycles where pix_en=1.
REQ-014 hcount shall run 0..H_TOTAL-1 and then wrap to 0, where H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP; vcount shall increment on each hcount wrap and run 0..V_TOTAL-1 before wrapping.
REQ-015 Line order shall be sync, back porch, active, front porch; raw HS shall be low for hcount<H_SYNC, and raw VS shall be low for vcount<V_SYNC.
REQ-016 Active region shall be H_SYNC+H_BP <= hcount < H_SYNC+H_BP+H_ACTIVE, with the same rule applied vertically; x and y shall be the counters minus their offsets.
REQ-017 Sprite i hit: sprite_en[i] and sx<=x<=sx+SPRITE_W-1 and sy<=y<=sy+SPRITE_H-1, evaluated in 11-bit arithmetic (no wrap); sprites extending off-screen are clipped.
REQ-018 Priority: lowest-index hit sprite wins; no hit gives BG_COLOR; outside the active region the output is 8'h00.
REQ-019 Pipeline: two pixel ticks from counter position to colour outputs; HS and VS shall be delayed by the same two ticks so they stay aligned with colour.
REQ-020 Shadow registers: sprite_x/y/color/en shall be captured only on the endofframe tick; mid-frame input changes shall not affect the frame currently being drawn.
REQ-021 endofframe shall be high for exactly one clk50M cycle, the pix_en cycle where vcount=V_SYNC+V_BP+V_ACTIVE and hcount=0.
REQ-022 frame_count shall increment on each endofframe pulse and wrap from 16'hFFFF to 0.

Reset
REQ-023 reset shall asynchronously clear pix_en, hcount, vcount, pipeline registers, red/green/blue, frame_count, collision and shadow enables to 0, and shall force HS=VS=1.
REQ-024 Reset asserted mid-line or mid-frame shall abort immediately; after release, the first tick shall start at hcount=vcount=0 with no endofframe pulse for the partial frame.

Configuration
REQ-025 With VGA_COLLISION_EN defined: a sticky accumulator bit i shall set when sprite i and at least one other sprite both hit the same active pixel.
REQ-026 With VGA_COLLISION_EN defined: on endofframe the accumulator shall be copied to collision and cleared in the same cycle, with any same-cycle hits counting toward the next frame.
REQ-027 Without VGA_COLLISION_EN: the collision port and accumulator logic shall be absent, and all other behaviour shall be unchanged.

Structure
REQ-028 Package vga_pkg shall hold the RGB332 field widths, the default timing constants, and the rgb332 typedef.
REQ-029 Sub-module vga_timing shall own pix_en, hcount/vcount, raw syncs, the active flag and the endofframe tick; the compositor shall own hit test, priority, shadows, pipeline and collision.

Verification
REQ-030 Scenario: reset release, 2 frames at default timing -> HS period 1600 clk50M, low 192; VS low 2 lines; endofframe every 840000 clk50M; frame_count=2.
REQ-031 Scenario: sprite0 en at (0,0) colour 8'hE0 -> pixels x,y 0..7 read 8'hE0, x=8 reads 8'h21, colour appears 2 ticks after counter reaches hcount=144.
REQ-032 Scenario: sprite0 (100,100) 8'hFF and sprite1 (104,104) 8'h03 -> overlap pixel (105,105)=8'hFF; with macro, collision=3'b011 after endofframe, and 3'b000 a frame after sprite1 is disabled.
REQ-033 Scenario: sprite0 at (636,476) -> only the 4x4 on-screen corner is drawn; no wrap to x=0 or y=0.
REQ-034 Scenario: sprite_x changed at line 200 -> unchanged image until the next endofframe, new position from the following frame.
REQ-035 Scenario: reset pulsed at hcount=300, vcount=250 -> outputs 0, HS=VS=1 immediately; restart at 0,0; frame_count=0.
